shift_reg_break_dv_compact: RTL and testbench
=============================================

// Module: shift_reg_break_dv_compact
// PURPOSE
//  Data-carrying, parametrised shift-register buffer that breaks the data/valid path: every
//  token traverses exactly NUM_SLOTS registers before reaching outs. Next generation of the
//  dataless lock-step shift buffer: adds a DATA_TYPE payload and an occupancy count, plus an
//  optional bubble-collapse mode in which empty slots advance while the output stalls.
//  Used by the buffer-placement pass wherever a multi-cycle DV break with payload is needed.
// PARAMETERS
//  NUM_SLOTS  4  number of register stages; legal >= 2
//  DATA_TYPE  32 payload width in bits; legal >= 1
// PORTS
//  clk        in   1                  clock, all state updates on rising edge
//  rst        in   1                  reset, synchronous, active-high
//  ins        in   DATA_TYPE          input payload
//  ins_valid  in   1                  input token valid
//  ins_ready  out  1                  buffer accepts ins this cycle
//  outs       out  DATA_TYPE          output payload = data of slot NUM_SLOTS-1
//  outs_valid out  1                  = valid of slot NUM_SLOTS-1
//  outs_ready in   1                  consumer accepts outs this cycle
//  occupancy  out  $clog2(NUM_SLOTS+1) number of valid slots (registered)
// BEHAVIOUR
//  - Reset: all valid bits 0, occupancy 0 -> outs_valid=0, ins_ready=1; data regs need no reset
//    (outs is don't-care while outs_valid=0). Reset mid-operation drops all tokens in one cycle.
//  - Slot 0 loads {ins_valid, ins}; slot i loads slot i-1 whenever slot i is enabled (en[i]).
//  - Transfer in: ins_valid & ins_ready. Transfer out: outs_valid & outs_ready.
//  - Lock-step mode (macro absent): single enable en = ~outs_valid | outs_ready for all slots;
//    ins_ready = en. Stall holds every slot, bubbles included. Invalid inputs shift in as bubbles.
//  - Latency: token accepted at cycle t appears on outs at cycle t+NUM_SLOTS if never stalled.
//  - occupancy_next = occupancy + xfer_in - xfer_out; simultaneous in/out leaves it unchanged;
//    never exceeds NUM_SLOTS; equals popcount(valid) at all times (assertion).
//  - Full (all slots valid) with outs_ready=0: ins_ready=0, all state held.
//  - outs_ready -> ins_ready is a combinational path by design; ins_valid -> outs_valid is not.
//  - Payload ordering is strict FIFO; no token duplicated or lost.
// CONFIGURATION
//  SHIFT_REG_BUBBLE_COLLAPSE_EN defined: per-slot enable
//    en[NUM_SLOTS-1] = ~valid[NUM_SLOTS-1] | outs_ready;  en[i] = ~valid[i] | en[i+1];
//    ins_ready = en[0]. A bubble below a stalled token is overwritten by its upstream slot,
//    so up to NUM_SLOTS tokens queue under stall; min latency unchanged (NUM_SLOTS).
//  Undefined: lock-step behaviour above; en[i] = en for all i. Ports identical in both builds.
// STRUCTURE
//  - Package shift_reg_pkg: function occ_width(n)=$clog2(n+1); no typedefs needed elsewhere.
//  - Sub-module shift_reg_slot: one valid+data register with enable; top instantiates
//    NUM_SLOTS in a generate loop and computes the enable chain and occupancy counter.
// TESTING
//  - Reset: assert rst with 3 tokens inside -> next cycle outs_valid=0, occupancy=0, ins_ready=1.
//  - Streaming: NUM_SLOTS=4, outs_ready=1, push 0x11..0x18 back-to-back -> 0x11 at outs
//    cycle t+4, then one token/cycle in order; occupancy steady at 4.
//  - Full stall: fill 4 tokens, outs_ready=0 -> ins_ready=0, outs holds first token, occupancy=4;
//    release -> both transfers same cycle, occupancy stays 4.
//  - Bubbles under stall: push A, idle 2 cycles, push B, stall when A at outs -> lock-step build:
//    ins_ready=0, B stays 3 slots back; collapse build: ins_ready=1, B advances to slot 2 in 2 cycles.
//  - Random: random ins_valid/outs_ready 10k cycles, DATA_TYPE=8, NUM_SLOTS in {2,5} -> scoreboard
//    FIFO order, occupancy == popcount(valid), no loss/duplication, both macro builds.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared helpers for the payload-carrying shift-register DV break.
package shift_reg_pkg;

  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_reg_break_dv_compact_slot.sv
// One stage of the shift buffer: a valid bit and a payload register that load together when enabled.
module shift_reg_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  logic             valid_d;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    valid_d = en ? in_valid : valid_q;
    data_d  = en ? in_data  : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // Payload is meaningless while its valid bit is low, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/shift_reg_break_dv_compact.sv
// Multi-stage data/valid break carrying a payload; every token crosses NUM_SLOTS registers.
// Define SHIFT_REG_BUBBLE_COLLAPSE_EN to let empty slots advance while the output is stalled.
module shift_reg_break_dv_compact
  import shift_reg_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_TYPE = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_TYPE-1:0]              ins,
  input  logic                              ins_valid,
  output logic                              ins_ready,
  output logic [DATA_TYPE-1:0]              outs,
  output logic                              outs_valid,
  input  logic                              outs_ready,
  output logic [occ_width(NUM_SLOTS)-1:0]   occupancy
);

  localparam int OW = occ_width(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] en;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [DATA_TYPE-1:0] slot_data [NUM_SLOTS];
  logic                 xfer_in;
  logic                 xfer_out;
  logic [OW-1:0]        occupancy_d;
  logic [OW-1:0]        occupancy_q;

`ifdef SHIFT_REG_BUBBLE_COLLAPSE_EN
  logic hole_seen;

  // A slot may move whenever any slot at or beyond it is empty, or the consumer drains the tail.
  always_comb begin
    hole_seen = 1'b0;
    en        = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      hole_seen = hole_seen | ~slot_valid[i];
      en[i]     = hole_seen | outs_ready;
    end
  end
`else
  always_comb begin
    en = {NUM_SLOTS{~slot_valid[NUM_SLOTS-1] | outs_ready}};
  end
`endif

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    if (i == 0) begin : g_head
      shift_reg_slot #(.WIDTH(DATA_TYPE)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .en       (en[0]),
        .in_valid (ins_valid),
        .in_data  (ins),
        .valid_q  (slot_valid[0]),
        .data_q   (slot_data[0])
      );
    end else begin : g_body
      shift_reg_slot #(.WIDTH(DATA_TYPE)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .en       (en[i]),
        .in_valid (slot_valid[i-1]),
        .in_data  (slot_data[i-1]),
        .valid_q  (slot_valid[i]),
        .data_q   (slot_data[i])
      );
    end
  end

  assign ins_ready  = en[0];
  assign outs       = slot_data[NUM_SLOTS-1];
  assign outs_valid = slot_valid[NUM_SLOTS-1];
  assign xfer_in    = ins_valid & ins_ready;
  assign xfer_out   = outs_valid & outs_ready;
  assign occupancy  = occupancy_q;

  always_comb begin
    occupancy_d = occupancy_q + OW'(xfer_in) - OW'(xfer_out);
  end

  always_ff @(posedge clk) begin
    if (rst) occupancy_q <= '0;
    else     occupancy_q <= occupancy_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occupancy_q == OW'($countones(slot_valid)));
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg_break_dv_compact.sv
// Scoreboard bench for shift_reg_break_dv_compact: three depths share stimulus, each checked by a
// token-position model; works with or without SHIFT_REG_BUBBLE_COLLAPSE_EN.
module tb_shift_reg_break_dv_compact;

`ifdef SHIFT_REG_BUBBLE_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ins_valid;
  logic [7:0] ins;
  logic       outs_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int ns,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s slots=%0d t=%0t got=%0h expected=%0h", name, ns, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic rs);
    @(posedge clk);
    #1;
    ins_valid  = v;
    ins        = d;
    outs_ready = r;
    rst        = rs;
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int NS = (g == 0) ? 4 : ((g == 1) ? 2 : 5);

    logic [7:0]                 outs;
    logic                       outs_valid;
    logic                       ins_ready;
    logic [$clog2(NS+1)-1:0]    occupancy;

    // Slot index of every token in flight (oldest first) and its expected payload.
    int         pos_q[$];
    logic [7:0] sb_q[$];

    shift_reg_break_dv_compact #(.NUM_SLOTS(NS), .DATA_TYPE(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
      .occupancy  (occupancy)
    );

    always @(negedge clk) begin : model
      int  n;
      bit  exp_ov;
      bit  head_stall;
      bit  exp_ready;
      bit  blk [NS];
      int  nxt[$];
      if (rst) begin
        pos_q.delete();
        sb_q.delete();
      end else begin
        n          = pos_q.size();
        exp_ov     = (n > 0) && (pos_q[0] == NS - 1);
        head_stall = exp_ov && !outs_ready;
        for (int k = 0; k < n; k++) begin
          if (!COLLAPSE || k == 0) blk[k] = head_stall;
          else                     blk[k] = blk[k-1] && (pos_q[k] + 1 == pos_q[k-1]);
        end
        if (COLLAPSE) begin
          exp_ready = 1'b1;
          if (n > 0) begin
            if (pos_q[n-1] == 0 && blk[n-1]) exp_ready = 1'b0;
          end
        end else begin
          exp_ready = !head_stall;
        end
        checkOutput("outs_valid", NS, outs_valid, exp_ov);
        checkOutput("ins_ready", NS, ins_ready, exp_ready);
        checkOutput("occupancy", NS, occupancy, n);
        nxt = {};
        for (int k = 0; k < n; k++) begin
          if (!(k == 0 && exp_ov && outs_ready))
            nxt.push_back(blk[k] ? pos_q[k] : pos_q[k] + 1);
        end
        if (ins_valid && exp_ready) begin
          nxt.push_back(0);
          sb_q.push_back(ins);
        end
        pos_q = nxt;
      end
    end

    always @(negedge clk) begin : monitor
      if (!rst && outs_valid && outs_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_token slots=%0d t=%0t got=%0h expected=none", NS, $time, outs);
        end else begin
          checkOutput("outs_data", NS, outs, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int p_in;
    int p_out;
    rst        = 1'b1;
    ins_valid  = 1'b0;
    ins        = 8'h00;
    outs_ready = 1'b0;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset with tokens inside.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("reset_outs_valid", 4, gen_cfg[0].outs_valid, 0);
    checkOutput("reset_occupancy", 4, gen_cfg[0].occupancy, 0);
    checkOutput("reset_ins_ready", 4, gen_cfg[0].ins_ready, 1);

    // Back-to-back streaming, then drain.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h11 + i), 1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill and stall, then release with simultaneous in/out.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
    checkOutput("full_ins_ready", 4, gen_cfg[0].ins_ready, 0);
    checkOutput("full_occupancy", 4, gen_cfg[0].occupancy, 4);
    checkOutput("full_outs", 4, gen_cfg[0].outs, 8'h21);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h31 + i), 1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubbles below a stalled token.
    applyStimulus(1'b1, 8'hA0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("bubble_outs", 4, gen_cfg[0].outs, 8'hA0);
    checkOutput("bubble_ins_ready", 4, gen_cfg[0].ins_ready, COLLAPSE ? 1 : 0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with shifting densities.
    p_in  = 50;
    p_out = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        p_in  = $urandom_range(10, 95);
        p_out = $urandom_range(10, 95);
      end
      applyStimulus($urandom_range(0, 99) < p_in, 8'($urandom), $urandom_range(0, 99) < p_out, 1'b0);
    end

    repeat (12) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("drain_empty", 4, gen_cfg[0].sb_q.size(), 0);
    checkOutput("drain_empty", 2, gen_cfg[1].sb_q.size(), 0);
    checkOutput("drain_empty", 5, gen_cfg[2].sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
